// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for a first-word-fall-through read port; the default is a registered read.
module sync_fifo_flags #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT    = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_CNT    = (ASIZE+1)'(AE_LEVEL);
    localparam logic [ASIZE:0] ONE_CNT   = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] ZERO_CNT  = '0;

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_wfull;
    logic             r_rempty;
    logic             r_walmost_full;
    logic             r_ralmost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wacc;
    logic             w_racc;
    logic [ASIZE:0]   w_count_nxt;

    // Acceptance is gated only by this cycle's registered flags, so full/empty
    // never depend combinationally on the opposite port.
    always_comb begin
        w_wacc      = winc && !r_wfull;
        w_racc      = rinc && !r_rempty;
        w_count_nxt = r_count;
        if (w_wacc && !w_racc) begin
            w_count_nxt = r_count + ONE_CNT;
        end else if (!w_wacc && w_racc) begin
            w_count_nxt = r_count - ONE_CNT;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_wacc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_wfull         <= 1'b0;
            r_rempty        <= 1'b1;
            r_walmost_full  <= (ZERO_CNT >= AF_CNT);
            r_ralmost_empty <= 1'b1;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            if (w_wacc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_racc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count         <= w_count_nxt;
            r_wfull         <= (w_count_nxt == DEPTH_CNT);
            r_rempty        <= (w_count_nxt == ZERO_CNT);
            r_walmost_full  <= (w_count_nxt >= AF_CNT);
            r_ralmost_empty <= (w_count_nxt <= AE_CNT);
            // A new error on the same edge as clr_err stays set.
            if (winc && r_wfull) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc && r_rempty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always on the bus; rinc pops what is already displayed.
    assign rdata  = r_mem[r_rptr];
    assign rvalid = !r_rempty;
`else
    logic [DSIZE-1:0] r_rdata;
    logic             r_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_racc;
            if (w_racc) begin
                r_rdata <= r_mem[r_rptr];
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
`endif

    assign wfull         = r_wfull;
    assign rempty        = r_rempty;
    assign walmost_full  = r_walmost_full;
    assign ralmost_empty = r_ralmost_empty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule
